fast_floor_q_to_bba: RTL and testbench

- Upstream neighbour of the BBa->q fastBConvEx stage in the BEHZ homomorphic-multiply path.
- Takes a tensored ciphertext polynomial held in both q and BBa bases and computes the approximate scaled floor y = (t*x - fastBConv(t*x mod q)) * q^-1 in basis BBa.
- y is a floor(t*x/q) approximation, off by at most a small integer error.
- The BBa output feeds the BBa->q fastBConvEx stage directly.

---
 rtl/fast_floor_q_to_bba_pkg.sv | 50 +++++
 rtl/fast_floor_q_to_bba_if.sv | 30 +++
 rtl/fast_bconv.sv | 69 ++++++
 rtl/fast_floor_q_to_bba_sub_mulmod.sv | 29 ++
 rtl/fast_floor_q_to_bba.sv | 126 ++++++++++++
 tb/tb_fast_floor_q_to_bba.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/fast_floor_q_to_bba_pkg.sv
// Shared RNS basis tables, residue types and modular helpers for the q -> BBa
// scaled-floor stage of the BEHZ multiply path (toy parameter set).
package fast_floor_q_to_bba_pkg;

   localparam int RNS_PRIME_BITS = 5;
   localparam int N_SLOTS        = 4;
   localparam int q_BASIS_LEN    = 2;
   localparam int BBa_BASIS_LEN  = 2;

   typedef logic [RNS_PRIME_BITS-1:0] rns_residue_t;
   typedef rns_residue_t [q_BASIS_LEN-1:0]                  q_vec_t;
   typedef rns_residue_t [BBa_BASIS_LEN-1:0]                bba_vec_t;
   typedef q_vec_t [BBa_BASIS_LEN-1:0]                      bconv_mat_t;
   typedef rns_residue_t [N_SLOTS-1:0][q_BASIS_LEN-1:0]     q_poly_t;
   typedef rns_residue_t [N_SLOTS-1:0][BBa_BASIS_LEN-1:0]   bba_poly_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam rns_residue_t T_PLAIN = 5'd3;

   // Index 0 is the first prime; B primes precede the Ba prime in BBa.
   localparam q_vec_t     q_BASIS      = {5'd11, 5'd7};
   localparam bba_vec_t   BBa_BASIS    = {5'd17, 5'd13};
   localparam q_vec_t     z_MOD_q      = {5'd8, 5'd2};
   localparam bconv_mat_t y_q_TO_BBa   = {{5'd7, 5'd11}, {5'd7, 5'd11}};
   localparam bba_vec_t   qinv_MOD_BBa = {5'd2, 5'd12};

   function automatic rns_residue_t mod_reduce(
      input logic [2*RNS_PRIME_BITS-1:0] v,
      input rns_residue_t                p
   );
      return rns_residue_t'(v % {{RNS_PRIME_BITS{1'b0}}, p});
   endfunction

   function automatic rns_residue_t mul_mod(
      input rns_residue_t a,
      input rns_residue_t b,
      input rns_residue_t p
   );
      logic [2*RNS_PRIME_BITS-1:0] prod;
      prod = {{RNS_PRIME_BITS{1'b0}}, a} * {{RNS_PRIME_BITS{1'b0}}, b};
      return mod_reduce(prod, p);
   endfunction

endpackage

// File: rtl/fast_floor_q_to_bba_if.sv
// Polynomial handshake bundle between the producer of tensored ciphertexts
// and the scaled-floor block.
interface fast_floor_q_to_bba_if;
   import fast_floor_q_to_bba_pkg::*;

   logic      in_valid;
   logic      in_ready;
   q_poly_t   input_q;
   bba_poly_t input_BBa;
   logic      out_valid;
   bba_poly_t output_BBa;

   modport master (
      output in_valid,
      output input_q,
      output input_BBa,
      input  in_ready,
      input  out_valid,
      input  output_BBa
   );

   modport slave (
      input  in_valid,
      input  input_q,
      input  input_BBa,
      output in_ready,
      output out_valid,
      output output_BBa
   );
endinterface

// File: rtl/fast_bconv.sv
// Approximate fast base conversion: x_i = sum_j [x_j * z_j]_{p_j} * (P/p_j) mod m_i,
// two register stages (per-prime scaling, then per-output accumulation).
module fast_bconv
   import fast_floor_q_to_bba_pkg::*;
#(
   parameter int IN_LEN  = q_BASIS_LEN,
   parameter int OUT_LEN = BBa_BASIS_LEN,
   parameter logic [IN_LEN-1:0][RNS_PRIME_BITS-1:0]              IN_BASIS  = q_BASIS,
   parameter logic [OUT_LEN-1:0][RNS_PRIME_BITS-1:0]             OUT_BASIS = BBa_BASIS,
   parameter logic [IN_LEN-1:0][RNS_PRIME_BITS-1:0]              IN_Z      = z_MOD_q,
   parameter logic [OUT_LEN-1:0][IN_LEN-1:0][RNS_PRIME_BITS-1:0] Y_MAT     = y_q_TO_BBa
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic [N_SLOTS-1:0][IN_LEN-1:0][RNS_PRIME_BITS-1:0]  in_data,
   output logic out_valid,
   output logic [N_SLOTS-1:0][OUT_LEN-1:0][RNS_PRIME_BITS-1:0] out_data
);

   logic [N_SLOTS-1:0][IN_LEN-1:0][RNS_PRIME_BITS-1:0]  a_r;
   logic [N_SLOTS-1:0][OUT_LEN-1:0][RNS_PRIME_BITS-1:0] acc_s;
   logic [RNS_PRIME_BITS:0]                             sum_s;
   logic                                                s1_valid_r;

   // Per-output modular accumulation; each addend is already reduced, so one conditional subtract suffices.
   always_comb begin
      acc_s = '0;
      sum_s = '0;
      for (int k = 0; k < N_SLOTS; k++) begin
         for (int i = 0; i < OUT_LEN; i++) begin
            sum_s = '0;
            for (int j = 0; j < IN_LEN; j++) begin
               sum_s = sum_s + {1'b0, mul_mod(a_r[k][j], Y_MAT[i][j], OUT_BASIS[i])};
               if (sum_s >= {1'b0, OUT_BASIS[i]}) begin
                  sum_s = sum_s - {1'b0, OUT_BASIS[i]};
               end else begin
                  sum_s = sum_s;
               end
            end
            acc_s[k][i] = sum_s[RNS_PRIME_BITS-1:0];
         end
      end
   end

   // Two-stage pipeline registers with a valid chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         a_r        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            for (int k = 0; k < N_SLOTS; k++) begin
               for (int j = 0; j < IN_LEN; j++) begin
                  a_r[k][j] <= mul_mod(in_data[k][j], IN_Z[j], IN_BASIS[j]);
               end
            end
         end
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            out_data <= acc_s;
         end
      end
   end

endmodule

// File: rtl/fast_floor_q_to_bba_sub_mulmod.sv
// Per-lane ((a - b) mod p) * c mod p with a, b already reduced below p.
module rns_sub_mulmod
   import fast_floor_q_to_bba_pkg::*;
#(
   parameter rns_residue_t MODULUS = 5'd13
) (
   input  rns_residue_t a,
   input  rns_residue_t b,
   input  rns_residue_t c,
   output rns_residue_t y
);

   logic signed [RNS_PRIME_BITS:0] diff_s;
   rns_residue_t                   diff_red_s;
   logic [2*RNS_PRIME_BITS-1:0]    prod_s;

   // Signed difference wraps into [0, p) before the multiply.
   always_comb begin
      diff_s = $signed({1'b0, a}) - $signed({1'b0, b});
      if (diff_s < $signed({(RNS_PRIME_BITS+1){1'b0}})) begin
         diff_red_s = rns_residue_t'(diff_s + $signed({1'b0, MODULUS}));
      end else begin
         diff_red_s = rns_residue_t'(diff_s);
      end
      prod_s = {{RNS_PRIME_BITS{1'b0}}, diff_red_s} * {{RNS_PRIME_BITS{1'b0}}, c};
      y      = mod_reduce(prod_s, MODULUS);
   end

endmodule

// File: rtl/fast_floor_q_to_bba.sv
// Scaled floor y = (t*x - fastBConv(t*x mod q)) * q^-1 in basis BBa; one
// polynomial in flight, result feeds the BBa -> q fastBConvEx stage.
module fast_floor_q_to_bba
   import fast_floor_q_to_bba_pkg::*;
#(
   parameter rns_residue_t PLAIN_T = T_PLAIN
) (
   input logic                 clk,
   input logic                 reset,
   fast_floor_q_to_bba_if.slave bus
);

   state_t    state_r;
   logic      in_ready_r;
   logic      out_valid_r;
   logic      conv_valid_r;
   q_poly_t   tx_q_r;
   q_poly_t   tx_q_s;
   bba_poly_t tx_BBa_r;
   bba_poly_t tx_BBa_s;
   bba_poly_t output_BBa_r;
   bba_poly_t result_s;
   bba_poly_t conv_out_s;
   logic      conv_out_valid_s;

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.output_BBa = output_BBa_r;

   // Scale incoming residues by t in both bases.
   always_comb begin
      tx_q_s   = '0;
      tx_BBa_s = '0;
      for (int k = 0; k < N_SLOTS; k++) begin
         for (int j = 0; j < q_BASIS_LEN; j++) begin
            tx_q_s[k][j] = mul_mod(PLAIN_T, bus.input_q[k][j], q_BASIS[j]);
         end
         for (int i = 0; i < BBa_BASIS_LEN; i++) begin
            tx_BBa_s[k][i] = mul_mod(PLAIN_T, bus.input_BBa[k][i], BBa_BASIS[i]);
         end
      end
   end

   fast_bconv #(
      .IN_LEN    (q_BASIS_LEN),
      .OUT_LEN   (BBa_BASIS_LEN),
      .IN_BASIS  (q_BASIS),
      .OUT_BASIS (BBa_BASIS),
      .IN_Z      (z_MOD_q),
      .Y_MAT     (y_q_TO_BBa)
   ) u_conv (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (conv_valid_r),
      .in_data   (tx_q_r),
      .out_valid (conv_out_valid_s),
      .out_data  (conv_out_s)
   );

   for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
      for (genvar i = 0; i < BBa_BASIS_LEN; i++) begin : g_prime
         rns_sub_mulmod #(
            .MODULUS (BBa_BASIS[i])
         ) u_lane (
            .a (tx_BBa_r[k][i]),
            .b (conv_out_s[k][i]),
            .c (qinv_MOD_BBa[i]),
            .y (result_s[k][i])
         );
      end
   end

   // Control FSM; conv launch is registered so the converter sees it the cycle after LAUNCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         conv_valid_r <= 1'b0;
         tx_q_r       <= '0;
         tx_BBa_r     <= '0;
         output_BBa_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               out_valid_r  <= 1'b0;
               conv_valid_r <= 1'b0;
               if (bus.in_valid) begin
                  tx_q_r     <= tx_q_s;
                  tx_BBa_r   <= tx_BBa_s;
                  in_ready_r <= 1'b0;
                  state_r    <= ST_LAUNCH;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               conv_valid_r <= 1'b1;
               state_r      <= ST_WAIT;
            end
            ST_WAIT: begin
               conv_valid_r <= 1'b0;
               if (conv_out_valid_s) begin
                  output_BBa_r <= result_s;
                  out_valid_r  <= 1'b1;
                  state_r      <= ST_DONE;
               end else begin
                  state_r      <= ST_WAIT;
               end
            end
            ST_DONE: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               out_valid_r  <= 1'b0;
               conv_valid_r <= 1'b0;
               in_ready_r   <= 1'b1;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fast_floor_q_to_bba.sv
// Directed bench for fast_floor_q_to_bba on the toy basis q={7,11}, B={13}, Ba={17}, t=3.
module tb_fast_floor_q_to_bba;
   import fast_floor_q_to_bba_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   int   pulses;
   bit   prev_ready;

   fast_floor_q_to_bba_if bus ();

   fast_floor_q_to_bba dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint observed, input longint expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Golden integer model: y = (3x - conv)/77 with conv the unreduced fastBConv sum.
   function automatic int model_y(input int x, input int p);
      int tx, a0, a1, conv, y;
      tx   = (3 * x) % 77;
      a0   = ((tx % 7) * 2) % 7;
      a1   = ((tx % 11) * 8) % 11;
      conv = a0 * 11 + a1 * 7;
      y    = (3 * x - conv) / 77;
      return ((y % p) + p) % p;
   endfunction

   function automatic int bba_prime(input int i);
      return (i == 0) ? 13 : 17;
   endfunction

   task automatic load_slot(input int s, input int x);
      bus.input_q[s][0]   = rns_residue_t'(x % 7);
      bus.input_q[s][1]   = rns_residue_t'(x % 11);
      bus.input_BBa[s][0] = rns_residue_t'(x % 13);
      bus.input_BBa[s][1] = rns_residue_t'(x % 17);
   endtask

   task automatic load_all(input int x0, input int x1, input int x2, input int x3);
      load_slot(0, x0);
      load_slot(1, x1);
      load_slot(2, x2);
      load_slot(3, x3);
   endtask

   task automatic check_outputs(input string tag, input int x0, input int x1, input int x2, input int x3);
      int xs[4];
      xs = '{x0, x1, x2, x3};
      for (int k = 0; k < N_SLOTS; k++) begin
         for (int i = 0; i < BBa_BASIS_LEN; i++) begin
            check(tag, bus.output_BBa[k][i], model_y(xs[k], bba_prime(i)));
         end
      end
   endtask

   task automatic do_txn(input int x0, input int x1, input int x2, input int x3);
      int edges;
      bit seen;
      @(negedge clk);
      load_all(x0, x1, x2, x3);
      check("ready_before_accept", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("ready_low_busy", bus.in_ready, 0);
      edges = 0;
      seen  = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk);
         #1;
         edges++;
         if (bus.out_valid) seen = 1'b1;
      end
      // out_valid lands in cycle L_conv+3 counting the accept cycle, i.e. 4 edges after the accept edge.
      check("latency_edges", edges, 4);
      check_outputs("result", x0, x1, x2, x3);
      @(posedge clk);
      #1;
      check("out_valid_single_pulse", bus.out_valid, 0);
      check("ready_after_done", bus.in_ready, 1);
      check_outputs("result_held", x0, x1, x2, x3);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      load_all(0, 0, 0, 0);
      #12;
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_output", bus.output_BBa, 0);
      @(negedge clk);
      reset = 1'b0;

      // x=52: y=1 in every slot
      do_txn(52, 52, 52, 52);
      for (int k = 0; k < N_SLOTS; k++) begin
         check("x52_B", bus.output_BBa[k][0], 1);
         check("x52_Ba", bus.output_BBa[k][1], 1);
      end

      // x=10: y=-1, negative-wrap path
      do_txn(10, 10, 10, 10);
      for (int k = 0; k < N_SLOTS; k++) begin
         check("x10_B", bus.output_BBa[k][0], 12);
         check("x10_Ba", bus.output_BBa[k][1], 16);
      end

      do_txn(0, 0, 0, 0);
      check("x0_all", bus.output_BBa, 0);

      do_txn(52, 10, 0, 76);

      // Back-to-back: in_valid held high, data switched to x=10 while busy.
      @(negedge clk);
      load_all(52, 52, 52, 52);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      load_all(10, 10, 10, 10);
      pulses     = 0;
      prev_ready = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            pulses++;
            if (pulses == 1) begin
               check("b2b_first_B", bus.output_BBa[0][0], 1);
               check("b2b_first_Ba", bus.output_BBa[3][1], 1);
            end else begin
               check("b2b_second_B", bus.output_BBa[0][0], 12);
               check("b2b_second_Ba", bus.output_BBa[3][1], 16);
            end
         end
         if (prev_ready && bus.in_valid) bus.in_valid = 1'b0;
         prev_ready = bus.in_ready;
      end
      check("b2b_pulses", pulses, 2);
      check("b2b_idle", bus.in_ready, 1);

      // Reset while waiting on the converter.
      @(negedge clk);
      load_all(52, 52, 52, 52);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_in_ready", bus.in_ready, 1);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_output", bus.output_BBa, 0);
      @(negedge clk);
      reset  = 1'b0;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) pulses++;
      end
      check("abort_no_output", pulses, 0);
      check("abort_output_still_zero", bus.output_BBa, 0);
      do_txn(52, 52, 52, 52);
      check("post_abort_B", bus.output_BBa[0][0], 1);
      check("post_abort_Ba", bus.output_BBa[0][1], 1);

      // Random slots against the integer model.
      for (int r = 0; r < 4; r++) begin
         do_txn(int'($urandom_range(0, 17016)), int'($urandom_range(0, 17016)),
                int'($urandom_range(0, 17016)), int'($urandom_range(0, 17016)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
